keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, is the number of clk cycles each column is driven before its rows are sampled (legal range 4 to 2^20).
REQ-002 Parameter DEBOUNCE_CNT, default 4, is the number of consecutive matching samples required to accept a press or a release (legal range 1 to 15).
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 row_in  input  4  keypad row lines, active-high, externally pulled low; bit 3 is row 1.
REQ-006 col_out  output  4  one-hot active-high column drive; bit 3 is column 1.
REQ-007 key_valid  output  1  one-cycle pulse marking a debounced new press.
REQ-008 key_code  output  4  hex code of the last accepted key; held until the next accepted key.
REQ-009 key_index  output  8  {col one-hot, row one-hot} of the last accepted key, with row in [3:0] and col in [7:4]; held like key_code.
REQ-010 key_down  output  1  high from the key_valid cycle until the release is accepted.

Function
REQ-011 row_in shall pass through a 2-flop synchronizer; all sampling shall use the synchronized value.
REQ-012 A dwell counter shall count 0..SCAN_DIV-1 and wrap; a sample event occurs on the cycle where the count equals SCAN_DIV-1.
REQ-013 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN:
- On each sample event with no valid press, col_out rotates right (1000->0100->0010->0001->1000).
- A valid press is exactly one synchronized row bit high. On a sample event with a valid press, the FSM captures col_out and the row, freezes col_out, sets the match count to 1, and goes to DEBOUNCE.
REQ-015 Zero rows high, or two or more rows high (ghost or multi-key), shall be treated as no press in every state.
REQ-016 DEBOUNCE, at each sample event:
- Rows equal to the captured row: increment the match count.
- Rows different: return to SCAN and rotate col_out.
REQ-017 When the match count reaches DEBOUNCE_CNT, in that same cycle:
- key_valid pulses.
- key_code and key_index update.
- key_down sets.
- The FSM goes to HELD.
- With DEBOUNCE_CNT=1, this occurs on the first matching sample in SCAN.
REQ-018 HELD: at a sample event where the captured row is low, go to RELEASE with the release count set to 1; otherwise stay.
REQ-019 RELEASE, at each sample event:
- Captured row low: increment the release count.
- Captured row high: return to HELD with no new key_valid.
- Release count reaches DEBOUNCE_CNT: clear key_down, rotate col_out, go to SCAN.
REQ-020 key_code map, rows 1-4 by columns 1-4:
- Row 1: 1, 2, 3, A.
- Row 2: 4, 5, 6, B.
- Row 3: 7, 8, 9, C.
- Row 4: E(*), 0, F(#), D.
REQ-021 A held key shall never produce a second key_valid; auto-repeat is out of scope.
REQ-022 Press latency: key_valid occurs exactly (DEBOUNCE_CNT-1)*SCAN_DIV cycles after the first accepting sample event.
REQ-023 Counter widths shall be sized from the parameters with no overflow at the legal maximums.

Reset
REQ-024 While rst_n is low at a clk edge, the block shall set:
- col_out=4'b1000; key_valid=0; key_code=0; key_index=0; key_down=0.
- FSM=SCAN; dwell, match and release counters=0; synchronizer flops=0.
REQ-025 Reset asserted mid-debounce or mid-hold shall abort that operation with no key_valid pulse.
REQ-026 After rst_n deasserts, the first sample event shall occur SCAN_DIV cycles later.

Structure
REQ-027 The package keypad_pkg shall hold:
- FSM state encodings.
- Row/column one-hot constants.
- The key_code lookup constants.
REQ-028 The sub-module keypad_sync shall implement the 2-flop row synchronizer; all other logic stays in keypad_scanner.

Verification
REQ-029 All directed scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3.
REQ-030 Reset: hold rst_n low for 3 cycles -> col_out=1000, key_code=0, key_down=0; col_out=0100 after 4 cycles with no key.
REQ-031 Clean press of row 2 / column 3 (key 6) held 200 cycles -> exactly one key_valid, key_code=6, key_index=8'b0010_0100; key_down stays high until 12+ cycles after release.
REQ-032 Bounce: the row toggles on alternate samples for 5 samples, then stays stable -> no key_valid during the bounce; exactly one key_valid after 3 stable samples.
REQ-033 Rows 1 and 3 both high on column 1 -> no key_valid, and col_out keeps rotating.
REQ-034 Release glitch: in HELD, the row drops for 1 sample and then returns -> no new key_valid and key_down stays 1.
REQ-035 Reset mid-debounce (after the 2nd matching sample) -> no key_valid; outputs return to their reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, one-hot constants and key_code lookup for keypad_scanner.
// Ports: none (package).
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [3:0] COL_RESET = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b1000;
    localparam logic [3:0] ROW2 = 4'b0100;
    localparam logic [3:0] ROW3 = 4'b0010;
    localparam logic [3:0] ROW4 = 4'b0001;
    localparam logic [3:0] COL1 = 4'b1000;
    localparam logic [3:0] COL2 = 4'b0100;
    localparam logic [3:0] COL3 = 4'b0010;
    localparam logic [3:0] COL4 = 4'b0001;

    // Indexed by {row position, column position}; entry 0 is row 1 / column 1.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Position of a one-hot line where bit 3 is line 1 (position 0).
    function automatic logic [1:0] onehot_pos(input logic [3:0] v);
        return v[3] ? 2'd0 : v[2] ? 2'd1 : v[1] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [3:0] col, input logic [3:0] row);
        return KEY_MAP[{onehot_pos(row), onehot_pos(col)}];
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad row/column lines plus decoded key outputs.
// Signals: row_in[3:0] rows (bit 3 = row 1), col_out[3:0] one-hot column drive,
//          key_valid press pulse, key_code[3:0], key_index[7:0] {col,row}, key_down level.
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] key_index;
    logic       key_down;

    modport master (input row_in, output col_out, key_valid, key_code, key_index, key_down);
    modport slave  (output row_in, input col_out, key_valid, key_code, key_index, key_down);
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous keypad row lines.
// Ports: clk clock, rst_n sync active-low reset, i_row[3:0] raw rows, o_row[3:0] synchronized rows.
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_row
);
    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row = r_sync;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with press/release debounce.
// Ports: clk clock, rst_n sync active-low reset,
//        kp (keypad_if.master): row_in in, col_out/key_valid/key_code/key_index/key_down out.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);
    import keypad_pkg::*;

    localparam int             DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DB_MAX    = 4'(DEBOUNCE_CNT);

    logic [3:0]    w_rows;
    logic [DW-1:0] r_dwell;
    state_t        r_state;
    logic [3:0]    r_col;
    logic [3:0]    r_row;
    logic [3:0]    r_match;
    logic [3:0]    r_rel;
    logic          r_valid;
    logic          r_down;
    logic [3:0]    r_code;
    logic [7:0]    r_index;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_row (kp.row_in),
        .o_row (w_rows)
    );

    logic       w_sample;
    logic       w_press;
    logic       w_hit;
    logic       w_accept;
    logic       w_released;
    logic [3:0] w_col_next;

    assign w_sample   = r_dwell == DWELL_MAX;
    // Exactly one row high; zero or several rows (ghosting) count as no press.
    assign w_press    = (w_rows != 4'd0) && ((w_rows & (w_rows - 4'd1)) == 4'd0);
    assign w_hit      = w_press && (w_rows == r_row);
    assign w_col_next = {r_col[0], r_col[3:1]};
    assign w_accept   = w_sample && w_press &&
                        ((r_state == SCAN && DEBOUNCE_CNT == 1) ||
                         (r_state == DEBOUNCE && w_hit && (r_match + 4'd1) == DB_MAX));
    assign w_released = w_sample && !w_hit &&
                        ((r_state == HELD && DEBOUNCE_CNT == 1) ||
                         (r_state == RELEASE && (r_rel + 4'd1) == DB_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n || w_sample) r_dwell <= '0;
        else r_dwell <= r_dwell + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SCAN;
            r_col   <= COL_RESET;
            r_row   <= '0;
            r_match <= '0;
            r_rel   <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
            r_code  <= '0;
            r_index <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_down  <= 1'b1;
                r_row   <= w_rows;
                r_code  <= key_lookup(r_col, w_rows);
                r_index <= {r_col, w_rows};
                r_match <= '0;
                r_state <= HELD;
            end else if (w_released) begin
                r_down  <= 1'b0;
                r_rel   <= '0;
                r_col   <= w_col_next;
                r_state <= SCAN;
            end else if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (w_press) begin
                            r_row   <= w_rows;
                            r_match <= 4'd1;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col <= w_col_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_hit) begin
                            r_match <= r_match + 4'd1;
                        end else begin
                            r_match <= '0;
                            r_col   <= w_col_next;
                            r_state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!w_hit) begin
                            r_rel   <= 4'd1;
                            r_state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (w_hit) begin
                            r_rel   <= '0;
                            r_state <= HELD;
                        end else begin
                            r_rel <= r_rel + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign kp.col_out   = r_col;
    assign kp.key_valid = r_valid;
    assign kp.key_code  = r_code;
    assign kp.key_index = r_index;
    assign kp.key_down  = r_down;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a modelled 4x4 key matrix.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic press_en = 1'b0;
    logic [3:0] press_col = 4'd0;
    logic [3:0] press_row = 4'd0;
    logic [3:0] prev_col;
    int checks = 0;
    int failures = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    keypad_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif)
    );

    // The pressed key connects its row to its column only while that column is driven.
    assign kif.row_in = (press_en && kif.col_out == press_col) ? press_row : 4'd0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && kif.key_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_key_valid actual code=%0h index=%0h expected no pulse at %0t",
                         kif.key_code, kif.key_index, $time);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("key_code", 32'(kif.key_code), 32'(e[11:8]));
                check("key_index", 32'(kif.key_index), 32'(e[7:0]));
                check("key_down_on_valid", 32'(kif.key_down), 32'd1);
            end
        end
    end

    task automatic wait_down(input logic v, input int lim);
        int n = 0;
        while (kif.key_down !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("key_down_wait", 32'(kif.key_down), 32'(v));
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_key(input logic [3:0] col, input logic [3:0] row);
        press_col = col;
        press_row = row;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_col", 32'(kif.col_out), 32'h8);
        check("reset_code", 32'(kif.key_code), 32'h0);
        check("reset_index", 32'(kif.key_index), 32'h0);
        check("reset_down", 32'(kif.key_down), 32'h0);
        check("reset_valid", 32'(kif.key_valid), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("col_before_first_sample", 32'(kif.col_out), 32'h8);
        @(negedge clk);
        check("col_after_first_sample", 32'(kif.col_out), 32'h4);

        // Key 6: row 2, column 3, held 200 cycles.
        set_key(4'b0010, 4'b0100);
        sb.push_back({4'h6, 8'b0010_0100});
        press_en = 1'b1;
        repeat (200) @(negedge clk);
        check("key6_drained", 32'(sb.size()), 32'd0);
        check("key6_down_held", 32'(kif.key_down), 32'd1);
        press_en = 1'b0;
        repeat (8) @(negedge clk);
        check("key6_down_after_release_8", 32'(kif.key_down), 32'd1);
        repeat (8) @(negedge clk);
        check("key6_down_after_release_16", 32'(kif.key_down), 32'd0);

        // Bounce on key 7 (row 3, column 1): toggle every sample period, then hold.
        set_key(4'b1000, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            press_en = (i % 2 == 0);
            repeat (4) @(negedge clk);
        end
        check("bounce_no_down", 32'(kif.key_down), 32'd0);
        sb.push_back({4'h7, 8'b1000_0010});
        press_en = 1'b1;
        wait_drain(100);
        repeat (40) @(negedge clk);
        press_en = 1'b0;
        wait_down(1'b0, 100);

        // Ghost: rows 1 and 3 on column 1; the scan must keep rotating.
        set_key(4'b1000, 4'b1010);
        press_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prev_col = kif.col_out;
            repeat (4) @(negedge clk);
            check("ghost_rotate", 32'(kif.col_out), 32'({prev_col[0], prev_col[3:1]}));
        end
        press_en = 1'b0;

        // Release glitch on key 1 (row 1, column 1).
        set_key(4'b1000, 4'b1000);
        sb.push_back({4'h1, 8'b1000_1000});
        press_en = 1'b1;
        wait_drain(100);
        repeat (8) @(negedge clk);
        press_en = 1'b0;
        repeat (4) @(negedge clk);
        press_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (4) @(negedge clk);
            check("glitch_down_held", 32'(kif.key_down), 32'd1);
        end
        press_en = 1'b0;
        wait_down(1'b0, 100);

        // Reset after the 2nd matching sample of key 0 (row 4, column 2).
        rst_n = 1'b0;
        set_key(4'b0100, 4'b0001);
        press_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_code_cleared", 32'(kif.key_code), 32'h0);
        rst_n = 1'b1;
        repeat (13) @(negedge clk);
        check("mid_debounce_col_frozen", 32'(kif.col_out), 32'h4);
        check("mid_debounce_no_down", 32'(kif.key_down), 32'd0);
        rst_n = 1'b0;
        press_en = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_col", 32'(kif.col_out), 32'h8);
        check("abort_index", 32'(kif.key_index), 32'h0);
        check("abort_down", 32'(kif.key_down), 32'h0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
